// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: multi-channel 7-segment display mux.
// Operates in manual-select or auto-scan mode, and can freeze the display.
// Ports:
//   Clock    - rising-edge clock.
//   Resetn   - synchronous active-low reset.
//   Din      - packed channel values.
//   Sel      - manual channel select.
//   Mode     - 0 = manual, 1 = auto-scan.
//   Hold     - freeze the scan.
//   Dwell    - dwell length in cycles, minus one.
//   seg7     - active-low segments, bit7 = DP.
//   ch_idx   - index of the channel being shown.
// Option: define SEG7_SCAN_DP_MARK_EN to light DP on channel 0 while scanning.
module seg7_scan_mux #(
  parameter int DATA_WIDTH  = 4,
  parameter int NUM_CH      = 5,
  parameter int SEL_WIDTH   = 3,
  parameter int DWELL_WIDTH = 8
) (
  input  logic                         Clock,
  input  logic                         Resetn,
  input  logic [NUM_CH*DATA_WIDTH-1:0] Din,
  input  logic [SEL_WIDTH-1:0]         Sel,
  input  logic                         Mode,
  input  logic                         Hold,
  input  logic [DWELL_WIDTH-1:0]       Dwell,
  output logic [7:0]                   seg7,
  output logic [SEL_WIDTH-1:0]         ch_idx
);

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    SCAN   = 2'd1,
    FROZEN = 2'd2
  } state_e;

  localparam logic [SEL_WIDTH-1:0] LAST =
    SEL_WIDTH'(NUM_CH - 1);

  state_e                   state_q, state_d;
  logic [SEL_WIDTH-1:0]     idx_q, idx_d;
  logic [DWELL_WIDTH-1:0]   cnt_q, cnt_d;
  logic [7:0]               seg_q, seg_d;
  logic [SEL_WIDTH-1:0]     chi_q, chi_d;

  logic                     load;
  logic [SEL_WIDTH-1:0]     show_ch;
  logic [SEL_WIDTH-1:0]     man_ch;
  logic [DATA_WIDTH-1:0]    ch_val;
  logic                     dp;

  function automatic logic [6:0] dec7(
    input logic [3:0] v
  );
    logic [6:0] s;
    s = 7'h7F;
    unique case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Out-of-range manual selects show the last channel.
  assign man_ch = (Sel > LAST) ? LAST : Sel;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    seg_d   = seg_q;
    chi_d   = chi_q;
    load    = 1'b0;
    show_ch = man_ch;
    unique case (state_q)
      MANUAL: begin
        load = 1'b1;
        if (Mode) begin
          state_d = SCAN;
          idx_d   = '0;
          cnt_d   = '0;
          show_ch = '0;
        end
      end
      SCAN, FROZEN: begin
        if (!Mode) begin
          state_d = MANUAL;
          load    = 1'b1;
        end else if (Hold) begin
          state_d = FROZEN;
        end else begin
          state_d = SCAN;
          load    = 1'b1;
          // >= so a Dwell lowered below the count advances at once.
          if (cnt_q >= Dwell) begin
            cnt_d = '0;
            idx_d = (idx_q == LAST) ? '0 : idx_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
          show_ch = idx_d;
        end
      end
      default: begin
        state_d = MANUAL;
      end
    endcase

    ch_val = Din[int'(show_ch)*DATA_WIDTH +: DATA_WIDTH];
`ifdef SEG7_SCAN_DP_MARK_EN
    dp = !((state_d != MANUAL) && (show_ch == '0));
`else
    dp = 1'b1;
`endif
    if (load) begin
      seg_d = {dp, dec7(4'(ch_val))};
      chi_d = show_ch;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= MANUAL;
      idx_q   <= '0;
      cnt_q   <= '0;
      seg_q   <= 8'hFF;
      chi_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
      chi_q   <= chi_d;
    end
  end

  assign seg7   = seg_q;
  assign ch_idx = chi_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb_seg7_scan_mux: directed bench for seg7_scan_mux.
// Expected outputs are queued per step and checked after the clock edge.
module tb_seg7_scan_mux;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic [19:0] Din;
  logic [2:0]  Sel;
  logic        Mode;
  logic        Hold;
  logic [7:0]  Dwell;
  logic [7:0]  seg7;
  logic [2:0]  ch_idx;

  int n_vec = 0;
  int n_err = 0;

  logic [10:0] exp_q[$];
  logic [3:0]  chv [5];

  logic [7:0] seg_tab [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0,
    8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83,
    8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic [7:0] hex_exp [8] = '{
    8'h80, 8'h90, 8'h88, 8'h83,
    8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  seg7_scan_mux dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .Din    (Din),
    .Sel    (Sel),
    .Mode   (Mode),
    .Hold   (Hold),
    .Dwell  (Dwell),
    .seg7   (seg7),
    .ch_idx (ch_idx)
  );

  always #5 Clock = ~Clock;

  task automatic set_ch(input int k, input logic [3:0] v);
    chv[k] = v;
    Din[k*4 +: 4] = v;
  endtask

  function automatic logic [7:0] scan_seg(input int k);
    logic [7:0] s;
    s = seg_tab[chv[k]];
`ifdef SEG7_SCAN_DP_MARK_EN
    if (k == 0) s[7] = 1'b0;
`endif
    return s;
  endfunction

  task automatic step(
    input logic [7:0] es,
    input logic [2:0] ec,
    input string      tag
  );
    logic [10:0] e;
    exp_q.push_back({es, ec});
    @(posedge Clock);
    #1;
    e = exp_q.pop_front();
    n_vec++;
    assert (seg7 === e[10:3]) else begin
      n_err++;
      $error("FAIL %s seg7 got %h want %h",
             tag, seg7, e[10:3]);
    end
    n_vec++;
    assert (ch_idx === e[2:0]) else begin
      n_err++;
      $error("FAIL %s ch_idx got %0d want %0d",
             tag, ch_idx, e[2:0]);
    end
  endtask

  initial begin
    int t;
    int k;
    Resetn = 1'b0;
    Mode   = 1'b1;
    Hold   = 1'b1;
    Sel    = 3'd0;
    Dwell  = 8'd2;
    Din    = '0;
    for (int i = 0; i < 5; i++) set_ch(i, 4'(i));
    set_ch(0, 4'h3);
    @(negedge Clock);

    step(8'hFF, 3'd0, "rst0");
    step(8'hFF, 3'd0, "rst1");

    Resetn = 1'b1;
    Mode   = 1'b0;
    Hold   = 1'b0;
    step(8'hB0, 3'd0, "rst_rel");

    set_ch(0, 4'h0);
    for (int s = 0; s < 8; s++) begin
      Sel = 3'(s);
      k = (s > 4) ? 4 : s;
      step(seg_tab[k], 3'(k), "sweep");
    end

    Sel = 3'd0;
    for (int v = 8; v < 16; v++) begin
      set_ch(0, 4'(v));
      step(hex_exp[v-8], 3'd0, "hex");
    end

    set_ch(0, 4'h0);
    Mode  = 1'b1;
    Dwell = 8'd2;
    for (int i = 0; i < 16; i++) begin
      k = (i / 3) % 5;
      step(scan_seg(k), 3'(k), "scan_d2");
    end

    Dwell = 8'd0;
    for (int i = 1; i <= 6; i++) begin
      k = i % 5;
      step(scan_seg(k), 3'(k), "scan_d0");
    end

    Mode  = 1'b0;
    Dwell = 8'd2;
    step(seg_tab[0], 3'd0, "to_man");
    Mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      k = i / 3;
      step(scan_seg(k), 3'(k), "to_ch2");
    end

    Hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_ch(2, (i % 2 == 0) ? 4'h7 : 4'h2);
      step(seg_tab[2], 3'd2, "frozen");
    end
    set_ch(2, 4'h9);
    Hold = 1'b0;
    step(seg_tab[9], 3'd2, "resume");
    step(scan_seg(3), 3'd3, "adv3");

    step(scan_seg(3), 3'd3, "cnt1");
    step(scan_seg(3), 3'd3, "cnt2");
    Dwell = 8'd1;
    step(scan_seg(4), 3'd4, "dw_shrink");
    step(scan_seg(4), 3'd4, "dw1_a");
    t = 0;
    step(scan_seg(t), 3'(t), "dw1_wrap");

    Resetn = 1'b0;
    step(8'hFF, 3'd0, "rst_mid");
    Resetn = 1'b1;
    Mode   = 1'b0;
    Sel    = 3'd3;
    step(seg_tab[3], 3'd3, "rel_man");

    Hold = 1'b1;
    Sel  = 3'd1;
    step(seg_tab[1], 3'd1, "man_hold");
    set_ch(1, 4'h5);
    step(seg_tab[5], 3'd1, "man_live");

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seg7_scan_mux.md
SEG7_SCAN_MUX -- requirements
Module: seg7_scan_mux

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, bits per channel value; legal range 1..4.
REQ-002 SHALL have parameter NUM_CH, default 5, number of input channels; legal range 2..8.
REQ-003 SHALL have parameter SEL_WIDTH, default 3, width of Sel and ch_idx; 2**SEL_WIDTH >= NUM_CH.
REQ-004 SHALL have parameter DWELL_WIDTH, default 8, width of the Dwell count.
REQ-005 SHALL have port Clock  input  1  sole clock, all state updates on its rising edge.
REQ-006 SHALL have port Resetn  input  1  synchronous active-low reset.
REQ-007 SHALL have port Din  input  NUM_CH*DATA_WIDTH  packed channels, channel k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port Sel  input  SEL_WIDTH  manual channel select.
REQ-009 SHALL have port Mode  input  1  0 = manual select, 1 = auto-scan.
REQ-010 SHALL have port Hold  input  1  freeze scan and display while in auto-scan.
REQ-011 SHALL have port Dwell  input  DWELL_WIDTH  cycles per channel minus one in auto-scan.
REQ-012 SHALL have port seg7  output  8  active-low common-anode segments, bit7 = DP, bits6..0 = g..a.
REQ-013 SHALL have port ch_idx  output  SEL_WIDTH  index of channel currently shown on seg7.

Function
REQ-014 seg7 and ch_idx SHALL be registered; latency from Sel/Din/Mode sample to seg7 = 1 cycle.
REQ-015 Decode SHALL be: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E (hex, DP bit included as 1); values narrower than 4 bits zero-extended.
REQ-016 FSM SHALL have states MANUAL, SCAN, FROZEN; reset state MANUAL.
REQ-017 Mode=0 SHALL force MANUAL from any state on the next edge; Hold ignored in MANUAL.
REQ-018 MANUAL: effective channel = Sel if Sel < NUM_CH, else NUM_CH-1 (out-of-range clamps to last channel).
REQ-019 MANUAL->SCAN when Mode=1: scan index and dwell counter SHALL load 0; first SCAN cycle shows channel 0.
REQ-020 SCAN: dwell counter increments each cycle; when counter == Dwell, index advances and counter clears.
REQ-021 Index SHALL wrap NUM_CH-1 -> 0; Dwell=0 advances every cycle.
REQ-022 Dwell changed mid-dwell SHALL take effect immediately; if counter already > new Dwell, advance on next cycle.
REQ-023 SCAN->FROZEN when Hold=1: counter, index, seg7, ch_idx hold their values; Din changes not displayed.
REQ-024 FROZEN->SCAN when Hold=0: counting resumes from the held counter value.
REQ-025 Din SHALL be resampled every non-frozen cycle, so a live change on the displayed channel appears after 1 cycle.

Reset
REQ-026 Resetn=0 at a rising edge SHALL set state MANUAL, seg7=8'hFF (blank), ch_idx=0, counter=0, scan index=0.
REQ-027 Reset SHALL override Mode and Hold; reset mid-scan discards progress; first cycle after release shows MANUAL selection.

Configuration
REQ-028 Macro SEG7_SCAN_DP_MARK_EN defined: seg7[7]=0 whenever ch_idx==0 in SCAN or FROZEN, marking frame start.
REQ-029 Macro SEG7_SCAN_DP_MARK_EN undefined: seg7[7]=1 at all times; no DP logic synthesised.

Verification
REQ-030 Reset: Resetn=0 two cycles -> seg7=8'hFF, ch_idx=0; release, Mode=0, Sel=0, ch0=3 -> seg7=8'hB0 next cycle.
REQ-031 Manual sweep: Sel=0..7, channels=4'h0,1,2,3,4 -> seg7 C0,F9,A4,B0,99,99,99,99; ch_idx 0,1,2,3,4,4,4,4.
REQ-032 Hex decode: DATA_WIDTH=4, ch0 = 8..F in turn, Sel=0 -> 80,90,88,83,C6,A1,86,8E.
REQ-033 Auto-scan: Mode=1, Dwell=2, NUM_CH=5 -> ch_idx 0,0,0,1,1,1,2... wraps 4->0 after 15 cycles; Dwell=0 -> changes every cycle.
REQ-034 Freeze: in SCAN at ch_idx=2 counter=1, Hold=1 for 10 cycles while ch2 toggles -> seg7/ch_idx constant; Hold=0 -> advance to 3 after 1 more cycle (Dwell=2).
REQ-035 DP mark: with SEG7_SCAN_DP_MARK_EN, ch0=0 in SCAN -> seg7=8'h40 on ch_idx 0; without macro -> 8'hC0; reset asserted mid-scan -> 8'hFF next edge.
